dm_responder: RTL and testbench
===============================

Name: dm_responder

Overview:
- Memory-side responder for the data-cache system port; answers SysStrobe/SysRW requests issued by the dcache on a cache miss or write-through.
- Holds a word-addressed data array, inserts a programmable number of wait states, then returns read data or commits write data and pulses SysReady.
- Sits between the cache's Sys* port and the DM address space and replaces the raw DM_* wiring in simulation and FPGA builds.

Parameters:
- ADDR_W, 10, word-address width; array depth is 2**ADDR_W words.
- LATENCY, 2, cycles from request acceptance to response; legal range 1..15.
- DATA_W, 32, data word width.

Ports:
- clock  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- SysStrobe  input  1  request valid; requester holds it high until it samples SysReady.
- SysRW  input  1  1 = read, 0 = write; sampled with SysStrobe.
- SysAddress  input  32  byte address; bits [ADDR_W+1:2] select the word, all other bits are ignored.
- SysData_in  input  DATA_W  write data from the requester.
- SysData_out  output  DATA_W  read data, valid while SysReady=1.
- SysReady  output  1  response strobe, high for one cycle per word.
- SysBusy  output  1  high whenever state is not IDLE.

Behaviour:
- Reset (async): state=IDLE, SysReady=0, SysData_out=0, SysBusy=0, wait counter=0. Array contents are not cleared.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: at edge N, if SysStrobe=1, latch SysRW, word address and SysData_in, load counter=LATENCY-1, then go to WAIT.
  - WAIT: each edge with counter!=0 decrements the counter. The edge at which counter==0 goes to RESP.
  - RESP, read: SysReady=1 and SysData_out=mem[addr]. Both are registered on the edge entering RESP, so they are visible from edge N+LATENCY.
  - RESP, write: mem[addr] is written on the edge entering RESP (N+LATENCY). SysReady=1 and SysData_out keeps its previous value.
  - RESP: the next edge returns to IDLE with SysReady=0.
- Latency: the response is visible in the cycle after edge N+LATENCY. Minimum request-to-request spacing is LATENCY+2 cycles.
- New requests are accepted only in IDLE. SysStrobe high in WAIT or RESP is treated as the same outstanding request and ignored. SysAddress, SysRW and SysData_in changing after acceptance have no effect.
- A requester that drops SysStrobe on the edge after sampling SysReady produces no spurious second request. If SysStrobe is still high in IDLE, it is a new request.
- Address wrap: word address uses modulo 2**ADDR_W (aliasing). Bits [1:0] are ignored, so misaligned addresses are treated as aligned.
- Reset mid-operation: the request is aborted. A write is not committed if reset asserts before the edge entering RESP, and no SysReady is produced.
- SysReady is never high in IDLE or WAIT.

Optional Feature:
- Macro: DM_RESP_BURST_EN.
- Enabled:
  - Adds input SysBurst (1 bit), sampled with SysStrobe.
  - A read with SysBurst=1 returns 4 words from the aligned 4-word block, critical word first, wrapping within the block (e.g. word 6 returns 6,7,4,5).
  - RESP holds for 4 consecutive cycles, with SysReady=1 each cycle and SysData_out updated each cycle.
  - A burst-write request is executed as a single write; SysBurst is ignored for writes.
- Disabled: no SysBurst port; every request is single-word.

Test Plan:
- Reset: assert reset mid-cycle -> SysReady=0, SysData_out=0, SysBusy=0 immediately without waiting for a clock edge.
- Write then read, LATENCY=2:
  - Write 0xDEADBEEF to SysAddress=0x0000_0010 -> SysReady pulses exactly 1 cycle, 2 edges after acceptance.
  - Read of 0x10 -> SysData_out=0xDEADBEEF with SysReady=1 at N+2.
- Held strobe: hold SysStrobe high through WAIT and RESP for a read of 0x20 -> exactly one SysReady pulse. Drop strobe next edge -> no second request.
- Aliasing, ADDR_W=10:
  - Write 0x1234 to 0x0000_1004 -> then reading 0x0000_0004 returns 0x1234.
  - Reading 0x0000_0007 also returns 0x1234.
- Reset during WAIT of a write of 0x55 to 0x40 (array previously 0x0) -> after reset, a read of 0x40 returns 0x0 and the aborted request produces no SysReady.
- DM_RESP_BURST_EN, mem[4..7]=A,B,C,D: burst read at 0x18 -> four SysReady cycles returning C,D,A,B, then IDLE. SysBusy=1 from acceptance until the edge after the last word.

Source files
------------

// File: rtl/dm_responder.sv
// Memory-side responder for the dcache Sys* port: word array with programmable wait states.
// Optional 4-word wrapping read bursts are enabled by defining DM_RESP_BURST_EN.
module dm_responder #(
    parameter int unsigned ADDR_W  = 10,
    parameter int unsigned LATENCY = 2,
    parameter int unsigned DATA_W  = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              SysStrobe,
    input  logic              SysRW,
    input  logic [31:0]       SysAddress,
    input  logic [DATA_W-1:0] SysData_in,
`ifdef DM_RESP_BURST_EN
    input  logic              SysBurst,
`endif
    output logic [DATA_W-1:0] SysData_out,
    output logic              SysReady,
    output logic              SysBusy
);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                rw_q, rw_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                rdy_q, rdy_d;
    logic [DATA_W-1:0]   dout_q, dout_d;
    logic                mem_we;
    logic [DATA_W-1:0]   mem [2**ADDR_W];
`ifdef DM_RESP_BURST_EN
    logic                burst_q, burst_d;
    logic [1:0]          beat_q, beat_d;
    logic [ADDR_W-1:0]   next_addr;
`endif

    // Word-select bits only; the rest of the byte address is don't-care.
    logic unused_addr;
    assign unused_addr = ^{SysAddress[31:ADDR_W+2], SysAddress[1:0]};

`ifdef DM_RESP_BURST_EN
    assign next_addr = {addr_q[ADDR_W-1:2], addr_q[1:0] + 2'd1};
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rw_d    = rw_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdy_d   = 1'b0;
        dout_d  = dout_q;
        mem_we  = 1'b0;
`ifdef DM_RESP_BURST_EN
        burst_d = burst_q;
        beat_d  = beat_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (SysStrobe) begin
                    rw_d    = SysRW;
                    addr_d  = SysAddress[ADDR_W+1:2];
                    wdata_d = SysData_in;
                    cnt_d   = 4'(LATENCY - 1);
`ifdef DM_RESP_BURST_EN
                    burst_d = SysBurst & SysRW;
                    beat_d  = 2'd0;
`endif
                    state_d = StWait;
                end
            end
            StWait: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = StResp;
                    rdy_d   = 1'b1;
                    if (rw_q) dout_d = mem[addr_q];
                    else      mem_we = 1'b1;
                end
            end
            StResp: begin
                state_d = StIdle;
`ifdef DM_RESP_BURST_EN
                // Critical word first, wrapping inside the aligned 4-word block.
                if (burst_q && beat_q != 2'd3) begin
                    state_d = StResp;
                    rdy_d   = 1'b1;
                    beat_d  = beat_q + 2'd1;
                    addr_d  = next_addr;
                    dout_d  = mem[next_addr];
                end
`endif
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            rw_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdy_q   <= 1'b0;
            dout_q  <= '0;
`ifdef DM_RESP_BURST_EN
            burst_q <= 1'b0;
            beat_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rw_q    <= rw_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdy_q   <= rdy_d;
            dout_q  <= dout_d;
`ifdef DM_RESP_BURST_EN
            burst_q <= burst_d;
            beat_q  <= beat_d;
`endif
        end
    end

    // Array contents survive reset.
    always_ff @(posedge clock) begin
        if (mem_we) mem[addr_q] <= wdata_q;
    end

    assign SysReady    = rdy_q;
    assign SysData_out = dout_q;
    assign SysBusy     = (state_q != StIdle);

endmodule

// File: tb/tb_dm_responder.sv
// Randomized self-checking bench for dm_responder against an array-based reference model.
module tb_dm_responder;

    localparam int unsigned ADDR_W  = 10;
    localparam int unsigned LATENCY = 2;
    localparam int unsigned DEPTH   = 1 << ADDR_W;

    logic        clock = 1'b0;
    logic        reset;
    logic        SysStrobe;
    logic        SysRW;
    logic [31:0] SysAddress;
    logic [31:0] SysData_in;
    logic [31:0] SysData_out;
    logic        SysReady;
    logic        SysBusy;
`ifdef DM_RESP_BURST_EN
    logic        SysBurst = 1'b0;
`endif

    dm_responder #(.ADDR_W(ADDR_W), .LATENCY(LATENCY), .DATA_W(32)) dut (
        .clock      (clock),
        .reset      (reset),
        .SysStrobe  (SysStrobe),
        .SysRW      (SysRW),
        .SysAddress (SysAddress),
        .SysData_in (SysData_in),
`ifdef DM_RESP_BURST_EN
        .SysBurst   (SysBurst),
`endif
        .SysData_out(SysData_out),
        .SysReady   (SysReady),
        .SysBusy    (SysBusy)
    );

    always #5 clock = ~clock;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] mem_m [DEPTH];
    bit          valid_m [DEPTH];
    logic [31:0] exp_dout;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_idle(input string tag);
        check_eq({tag, "_ready"}, 32'(SysReady), 32'd0);
        check_eq({tag, "_busy"}, 32'(SysBusy), 32'd0);
        check_eq({tag, "_dout"}, SysData_out, exp_dout);
    endtask

    // One transaction; abort_at >= 0 asserts reset in the cycle after edge N+abort_at.
    task automatic txn(input logic rw, input logic [31:0] addr, input logic [31:0] wdata,
                       input bit hold, input int abort_at);
        int unsigned widx;
        logic [31:0] rdata;
        bit          aborted;
        widx    = (addr >> 2) % DEPTH;
        rdata   = mem_m[widx];
        aborted = 1'b0;
        @(negedge clock);
        SysStrobe  = 1'b1;
        SysRW      = rw;
        SysAddress = addr;
        SysData_in = wdata;
        for (int k = 0; k <= int'(LATENCY); k++) begin
            @(negedge clock);
            check_eq("busy", 32'(SysBusy), 32'd1);
            check_eq("ready", 32'(SysReady), 32'(k == int'(LATENCY)));
            if (k == int'(LATENCY)) begin
                if (rw) exp_dout = rdata;
                check_eq(rw ? "rdata" : "wr_dout_hold", SysData_out, exp_dout);
            end
            if (k == abort_at) begin
                aborted   = 1'b1;
                SysStrobe = 1'b0;
                reset     = 1'b1;
                #1;
                exp_dout = 32'd0;
                check_idle("async_rst");
                @(negedge clock);
                reset = 1'b0;
                break;
            end
            if (!hold || k == int'(LATENCY)) SysStrobe = 1'b0;
            if (k < int'(LATENCY)) begin
                // Post-acceptance changes must be ignored.
                SysAddress = $urandom;
                SysData_in = $urandom;
                SysRW      = 1'($urandom);
            end
        end
        if (!rw && (abort_at < 0 || abort_at >= int'(LATENCY))) begin
            mem_m[widx]   = wdata;
            valid_m[widx] = 1'b1;
        end
        @(negedge clock);
        check_idle(aborted ? "post_abort" : "post_resp");
        @(negedge clock);
        check_idle("no_second_req");
    endtask

`ifdef DM_RESP_BURST_EN
    task automatic burst_read(input logic [31:0] addr);
        int unsigned widx;
        widx = (addr >> 2) % DEPTH;
        @(negedge clock);
        SysStrobe = 1'b1; SysRW = 1'b1; SysAddress = addr; SysBurst = 1'b1;
        for (int k = 0; k < int'(LATENCY) + 4; k++) begin
            @(negedge clock);
            SysStrobe = 1'b0; SysBurst = 1'b0;
            check_eq("b_busy", 32'(SysBusy), 32'd1);
            check_eq("b_ready", 32'(SysReady), 32'(k >= int'(LATENCY)));
            if (k >= int'(LATENCY)) begin
                exp_dout = mem_m[(widx & ~32'd3) | ((widx + k - LATENCY) & 32'd3)];
                check_eq("b_data", SysData_out, exp_dout);
            end
        end
        @(negedge clock);
        check_idle("b_end");
    endtask
`endif

    initial begin
        reset      = 1'b1;
        SysStrobe  = 1'b0;
        SysRW      = 1'b0;
        SysAddress = '0;
        SysData_in = '0;
        exp_dout   = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            mem_m[i]   = '0;
            valid_m[i] = 1'b0;
        end
        @(negedge clock);
        check_idle("reset");
        @(negedge clock);
        reset = 1'b0;

        txn(1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, -1);
        txn(1'b1, 32'h0000_0010, 32'h0, 1'b0, -1);
        txn(1'b0, 32'h0000_0020, 32'hCAFE_F00D, 1'b0, -1);
        txn(1'b1, 32'h0000_0020, 32'h0, 1'b1, -1);
        txn(1'b0, 32'h0000_1004, 32'h0000_1234, 1'b1, -1);
        txn(1'b1, 32'h0000_0004, 32'h0, 1'b0, -1);
        txn(1'b1, 32'h0000_0007, 32'h0, 1'b1, -1);

        // Aborted write during WAIT must not commit.
        txn(1'b0, 32'h0000_0040, 32'h0, 1'b0, -1);
        txn(1'b0, 32'h0000_0040, 32'h55, 1'b0, 0);
        txn(1'b1, 32'h0000_0040, 32'h0, 1'b0, -1);
        // Reset while a read response is on the bus clears outputs at once.
        txn(1'b1, 32'h0000_0010, 32'h0, 1'b0, int'(LATENCY));

        for (int i = 0; i < 40; i++) begin
            logic [31:0] a;
            logic        rw;
            a  = $urandom;
            rw = 1'($urandom) && valid_m[(a >> 2) % DEPTH];
            txn(rw, a, $urandom, 1'($urandom), -1);
        end

`ifdef DM_RESP_BURST_EN
        txn(1'b0, 32'h10, 32'hAAAA_0001, 1'b0, -1);
        txn(1'b0, 32'h14, 32'hBBBB_0002, 1'b0, -1);
        txn(1'b0, 32'h18, 32'hCCCC_0003, 1'b0, -1);
        txn(1'b0, 32'h1C, 32'hDDDD_0004, 1'b0, -1);
        burst_read(32'h18);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
